// File: rtl/lookup_engine_tcam_pkg.sv
// Shared types and constants for the TCAM lookup stage.
package lookup_pkg;
    typedef enum logic [1:0] {IDLE, CMP, RD, OUT} state_t;

    localparam int          CNT_W         = 32;
    localparam int unsigned DEFAULT_ACT_C = 32'h3f;
endpackage

// File: rtl/lookup_engine_tcam_tcam_array.sv
// Ternary CAM: per-entry key/mask/valid storage, parallel compare and
// lowest-index priority encode, result registered when cmp_en is high.
module tcam_array
    import lookup_pkg::*;
#(
    parameter int KEY_LEN = 197,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [KEY_LEN-1:0] wr_key,
    input  logic [KEY_LEN-1:0] wr_mask,
    input  logic               wr_vld,
    input  logic               cmp_en,
    input  logic [KEY_LEN-1:0] key,
    output logic               any_match,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);
    logic [DEPTH-1:0][KEY_LEN-1:0] ent_key;
    logic [DEPTH-1:0][KEY_LEN-1:0] ent_mask;
    logic [DEPTH-1:0]              ent_vld;
    logic [DEPTH-1:0]              match;
    logic [ADDR_W-1:0]             addr_nx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign match[i] = ent_vld[i] && ~|((key ^ ent_key[i]) & ent_mask[i]);
    end

    assign any_match = |match;

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        addr_nx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) addr_nx = ADDR_W'(i);
        end
    end

    // Key/mask contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_key[wr_addr]  <= wr_key;
            ent_mask[wr_addr] <= wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_vld <= '0;
            hit     <= 1'b0;
            addr    <= '0;
        end else begin
            if (wr_en) ent_vld[wr_addr] <= wr_vld;
            if (cmp_en) begin
                hit  <= any_match;
                addr <= addr_nx;
            end
        end
    end
endmodule

// File: rtl/lookup_engine_tcam.sv
// Match stage: ternary lookup of the extracted key, action RAM read on hit,
// DEFAULT_ACT on miss, PHV carried alongside, saturating hit/miss counters.
module lookup_engine_tcam
    import lookup_pkg::*;
#(
    parameter int                 STAGE       = 0,
    parameter int                 PHV_LEN     = 1124,
    parameter int                 KEY_LEN     = 197,
    parameter int                 ACT_LEN     = 625,
    parameter int                 DEPTH       = 16,
    parameter int                 ADDR_W      = $clog2(DEPTH),
    parameter logic [ACT_LEN-1:0] DEFAULT_ACT = ACT_LEN'(DEFAULT_ACT_C)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [PHV_LEN-1:0] phv_in,
    output logic [ACT_LEN-1:0] action_out,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               action_valid,
    input  logic               action_ready,
    output logic               match_hit,
    output logic [ADDR_W-1:0]  match_addr,
    input  logic               cam_wr_en,
    input  logic [ADDR_W-1:0]  cam_wr_addr,
    input  logic [KEY_LEN-1:0] cam_wr_key,
    input  logic [KEY_LEN-1:0] cam_wr_mask,
    input  logic               cam_wr_vld,
    input  logic               act_wr_en,
    input  logic [ADDR_W-1:0]  act_wr_addr,
    input  logic [ACT_LEN-1:0] act_wr_data,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    if (STAGE < 0 || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("lookup_engine_tcam: bad STAGE/DEPTH parameter");
    end

    state_t             state;
    logic [KEY_LEN-1:0] key_r;
    logic [ACT_LEN-1:0] act_mem [DEPTH];
    logic               any_match;

    assign key_ready = (state == IDLE);

    tcam_array #(
        .KEY_LEN (KEY_LEN),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_tcam (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (cam_wr_en),
        .wr_addr   (cam_wr_addr),
        .wr_key    (cam_wr_key),
        .wr_mask   (cam_wr_mask),
        .wr_vld    (cam_wr_vld),
        .cmp_en    (state == CMP),
        .key       (key_r),
        .any_match (any_match),
        .hit       (match_hit),
        .addr      (match_addr)
    );

    always_ff @(posedge clk) begin
        if (act_wr_en) act_mem[act_wr_addr] <= act_wr_data;
    end

    // The RD-cycle read sees the pre-edge RAM, so a same-cycle write returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            key_r        <= '0;
            action_valid <= 1'b0;
            action_out   <= '0;
            phv_out      <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (key_valid) begin
                    key_r   <= key_in;
                    phv_out <= phv_in;
                    state   <= CMP;
                end
                CMP: if (any_match) begin
                    state <= RD;
                end else begin
                    action_out   <= DEFAULT_ACT;
                    action_valid <= 1'b1;
                    state        <= OUT;
                end
                RD: begin
                    action_out   <= act_mem[match_addr];
                    action_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: if (action_ready) begin
                    action_valid <= 1'b0;
                    if (match_hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
